// File: rtl/divider_recon_checker.sv
// divider_recon_checker: rebuilds recon = q*d + r with an 8-step shift-add
// multiplier and reports the signed error n - recon for divider characterisation.
// Handshakes valid/ready on both the operand and the result side.
module divider_recon_checker #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] n,
  input  logic [W-1:0]   d,
  input  logic [W-1:0]   q,
  input  logic [W-1:0]   r,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] recon,
  output logic [2*W:0]   err,
  output logic           mismatch
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [2*W:0]    acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]  n_q, n_d;
  logic [W-1:0]    dv_q, dv_d;
  logic [W-1:0]    qv_q, qv_d;
  logic [2*W-1:0]  recon_q, recon_d;
  logic [2*W:0]    err_q, err_d;
  logic            mismatch_q, mismatch_d;

  logic            accept_s;
  logic [2*W:0]    addend_s;
  logic [2*W:0]    acc_step_s;
  logic [2*W:0]    err_step_s;

  // Operand-side ready: free in IDLE, or in DONE when the result is being taken.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_IDLE:  in_ready = 1'b1;
      S_DONE:  in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  // One shift-add step for the current quotient bit, and the error it would produce.
  always_comb begin
    addend_s = '0;
    if (qv_q[cnt_q]) begin
      addend_s = {{(W+1){1'b0}}, dv_q} << cnt_q;
    end else begin
      addend_s = '0;
    end
    acc_step_s = acc_q + addend_s;
    err_step_s = {1'b0, n_q} - {1'b0, acc_step_s[2*W-1:0]};
  end

  // Next-state and datapath update for the IDLE/MUL/DONE sequence.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    dv_d       = dv_q;
    qv_d       = qv_q;
    recon_d    = recon_q;
    err_d      = err_q;
    mismatch_d = mismatch_q;
    accept_s   = in_valid & in_ready;

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = S_MUL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        acc_d = acc_step_s;
        if (cnt_q == LAST_STEP) begin
          state_d    = S_DONE;
          recon_d    = acc_step_s[2*W-1:0];
          err_d      = err_step_s;
          mismatch_d = (err_step_s != '0);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          if (accept_s) begin
            state_d = S_MUL;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Operand capture happens only on the accept edge; later input changes are ignored.
    if (accept_s) begin
      n_d   = n;
      dv_d  = d;
      qv_d  = q;
      acc_d = {{(W+1){1'b0}}, r};
      cnt_d = '0;
    end else begin
      n_d = n_d;
    end
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      n_q        <= '0;
      dv_q       <= '0;
      qv_q       <= '0;
      recon_q    <= '0;
      err_q      <= '0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      dv_q       <= dv_d;
      qv_q       <= qv_d;
      recon_q    <= recon_d;
      err_q      <= err_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign recon     = recon_q;
  assign err       = err_q;
  assign mismatch  = mismatch_q;

endmodule

// File: tb/tb_divider_recon_checker.sv
// Directed testbench for divider_recon_checker with hand-computed expectations.
module tb_divider_recon_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] n;
  logic [7:0]  d;
  logic [7:0]  q;
  logic [7:0]  r;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] recon;
  logic [16:0] err;
  logic        mismatch;

  int n_cmp = 0;
  int n_bad = 0;
  int cycles;

  divider_recon_checker #(.W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .n         (n),
    .d         (d),
    .q         (q),
    .r         (r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .recon     (recon),
    .err       (err),
    .mismatch  (mismatch)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ops(input logic [15:0] nn, input logic [7:0] dd,
                           input logic [7:0] qq, input logic [7:0] rr);
    n = nn; d = dd; q = qq; r = rr;
  endtask

  // Accept one operand set, scramble inputs during MUL, wait for out_valid.
  task automatic start_and_wait(input string tag, input logic [15:0] nn, input logic [7:0] dd,
                                input logic [7:0] qq, input logic [7:0] rr);
    drive_ops(nn, dd, qq, rr);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    drive_ops(16'hA5A5, 8'h3C, 8'hC3, 8'h5A);
    check_eq({tag, ".in_ready_mul"}, {31'd0, in_ready}, 32'd0);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      tick();
      cycles++;
    end
    check_eq({tag, ".latency"}, cycles, 32'd8);
  endtask

  task automatic check_result(input string tag, input logic [15:0] er,
                              input logic [16:0] ee, input logic em);
    check_eq({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
    check_eq({tag, ".recon"}, {16'd0, recon}, {16'd0, er});
    check_eq({tag, ".err"}, {15'd0, err}, {15'd0, ee});
    check_eq({tag, ".mismatch"}, {31'd0, mismatch}, {31'd0, em});
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ".idle_out_valid"}, {31'd0, out_valid}, 32'd0);
    check_eq({tag, ".idle_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive_ops(16'd0, 8'd0, 8'd0, 8'd0);
    tick(); tick();
    rst = 1'b0;
    check_idle("reset");
    check_eq("reset.recon", {16'd0, recon}, 32'd0);
    check_eq("reset.err", {15'd0, err}, 32'd0);
    check_eq("reset.mismatch", {31'd0, mismatch}, 32'd0);
    tick();

    // Exact result: 14*7+2 = 100
    start_and_wait("exact", 16'd100, 8'd7, 8'd14, 8'd2);
    check_result("exact", 16'd100, 17'd0, 1'b0);
    tick();
    check_idle("exact");

    // Saturating: 255*255+255 = 65280, err 255
    start_and_wait("sat", 16'd65535, 8'd255, 8'd255, 8'd255);
    check_result("sat", 16'd65280, 17'd255, 1'b1);
    tick();
    check_idle("sat");

    // Negative error: 3*4 = 12, err 10-12 = -2
    start_and_wait("neg", 16'd10, 8'd4, 8'd3, 8'd0);
    check_result("neg", 16'd12, 17'h1FFFE, 1'b1);
    tick();
    check_idle("neg");

    // Zero divisor: recon = r
    start_and_wait("d0", 16'd5, 8'd0, 8'd9, 8'd5);
    check_result("d0", 16'd5, 17'd0, 1'b0);
    tick();

    // Backpressure: hold result for 5 cycles with a competing operand set offered
    out_ready = 1'b0;
    start_and_wait("bp", 16'd100, 8'd7, 8'd14, 8'd2);
    drive_ops(16'd1, 8'd1, 8'd1, 8'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp.in_ready", {31'd0, in_ready}, 32'd0);
      check_result("bp", 16'd100, 17'd0, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check_idle("bp");
    tick();
    check_idle("bp_stay");

    // Back-to-back: case 1 then case 3, second valid 9 cycles after the first
    drive_ops(16'd100, 8'd7, 8'd14, 8'd2);
    in_valid = 1'b1;
    tick();
    drive_ops(16'd10, 8'd4, 8'd3, 8'd0);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      tick();
      cycles++;
    end
    check_eq("b2b.latency1", cycles, 32'd8);
    check_result("b2b1", 16'd100, 17'd0, 1'b0);
    cycles = 0;
    tick();
    cycles++;
    in_valid = 1'b0;
    drive_ops(16'hFFFF, 8'hFF, 8'hFF, 8'hFF);
    check_eq("b2b.overlap_in_ready", {31'd0, in_ready}, 32'd0);
    while (!out_valid && cycles < 20) begin
      tick();
      cycles++;
    end
    check_eq("b2b.spacing", cycles, 32'd9);
    check_result("b2b2", 16'd12, 17'h1FFFE, 1'b1);
    tick();
    check_idle("b2b");

    // Mid-operation reset at the 4th MUL cycle
    drive_ops(16'd100, 8'd7, 8'd14, 8'd2);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("mrst");
    check_eq("mrst.recon", {16'd0, recon}, 32'd0);
    check_eq("mrst.err", {15'd0, err}, 32'd0);
    check_eq("mrst.mismatch", {31'd0, mismatch}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
    end
    check_eq("mrst.no_valid", {31'd0, out_valid}, 32'd0);
    start_and_wait("post_rst", 16'd65535, 8'd255, 8'd255, 8'd255);
    check_result("post_rst", 16'd65280, 17'd255, 1'b1);
    tick();
    check_idle("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
